// File: rtl/mem_bist_target_if.sv
// -----------------------------------------------------------------------------
// mem_bist_target_if
// Strobe / result bundle between the March-style BIST controller (master)
// and the memory-side responder (slave).
//
// Controller -> responder:
//   reset, preset, en, up_down : address counter control
//   write, read, data          : array access and expected/write data
//   fault_en, fault_addr,
//   fault_val                  : stuck-at injection on one cell
// Responder -> controller:
//   carry, is_equal            : combinational sweep-end and compare result
//   addr                       : registered counter value
//   fail_vld, fail_addr,
//   err_cnt                    : first-failure capture and mismatch count
// -----------------------------------------------------------------------------
interface mem_bist_target_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic              reset;
    logic              preset;
    logic              en;
    logic              up_down;
    logic              write;
    logic              read;
    logic              data;
    logic              fault_en;
    logic [ADDR_W-1:0] fault_addr;
    logic              fault_val;

    logic              carry;
    logic              is_equal;
    logic [ADDR_W-1:0] addr;
    logic              fail_vld;
    logic [ADDR_W-1:0] fail_addr;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output reset, preset, en, up_down, write, read, data,
               fault_en, fault_addr, fault_val,
        input  carry, is_equal, addr, fail_vld, fail_addr, err_cnt
    );

    modport slave (
        input  reset, preset, en, up_down, write, read, data,
               fault_en, fault_addr, fault_val,
        output carry, is_equal, addr, fail_vld, fail_addr, err_cnt
    );
endinterface

// File: rtl/mem_bist_target.sv
// -----------------------------------------------------------------------------
// mem_bist_target
// Memory-side responder for a March-style BIST controller: an up/down address
// counter, a DEPTH x 1 bit array, a read comparator, optional stuck-at fault
// injection on a single cell, and first-failure / mismatch-count debug state.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset (clears counter, array, debug state)
//   bus    : mem_bist_target_if.slave (controller strobes in, results out)
// -----------------------------------------------------------------------------
module mem_bist_target #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_bist_target_if.slave       bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Saturating increment for the mismatch counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0]  r_mem;
    logic              r_fail_vld;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [CNT_W-1:0]  r_err_cnt;

    logic w_at_max;
    logic w_at_zero;
    logic w_carry;
    logic w_fault_hit;
    logic w_rd;
    logic w_is_equal;
    logic w_mismatch;

    assign w_at_max  = (r_addr == '1);
    assign w_at_zero = (r_addr == '0);

    // Terminal count is only meaningful while counting; reset/preset do not
    // mask it, so the controller sees the sweep end on the same edge.
    assign w_carry = bus.en & ((bus.up_down & w_at_max) | (~bus.up_down & w_at_zero));

    // Injection masks reads only; the underlying cell still takes writes.
    assign w_fault_hit = bus.fault_en & (r_addr == bus.fault_addr);
    assign w_rd        = w_fault_hit ? bus.fault_val : r_mem[r_addr];

    // Compare uses pre-edge contents, so a same-cycle write is not seen.
    assign w_is_equal = ~bus.read | (w_rd == bus.data);
    assign w_mismatch = bus.read & ~w_is_equal;

    // Address counter: reset > preset > en, wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (bus.reset) begin
            r_addr <= '0;
        end else if (bus.preset) begin
            r_addr <= '1;
        end else if (bus.en) begin
            if (bus.up_down) begin
                r_addr <= r_addr + ADDR_ONE;
            end else begin
                r_addr <= r_addr - ADDR_ONE;
            end
        end
    end

    // Storage array, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (bus.write) begin
            r_mem[r_addr] <= bus.data;
        end
    end

    // First-failure capture is sticky; the counter keeps counting every miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_vld  <= 1'b0;
            r_fail_addr <= '0;
            r_err_cnt   <= '0;
        end else if (w_mismatch) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            if (!r_fail_vld) begin
                r_fail_vld  <= 1'b1;
                r_fail_addr <= r_addr;
            end
        end
    end

    assign bus.carry     = w_carry;
    assign bus.is_equal  = w_is_equal;
    assign bus.addr      = r_addr;
    assign bus.fail_vld  = r_fail_vld;
    assign bus.fail_addr = r_fail_addr;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_mem_bist_target.sv
module tb_mem_bist_target;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 16;
    localparam int CMAX   = 255;

    logic clk;
    logic rst_n;

    mem_bist_target_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mem_bist_target #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_addr;
    bit m_mem [DEPTH];
    bit m_fail_vld;
    int m_fail_addr;
    int m_err;

    task automatic model_clear();
        m_addr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
        m_fail_vld  = 1'b0;
        m_fail_addr = 0;
        m_err       = 0;
    endtask

    function automatic bit model_rd();
        if (bus.fault_en && int'(bus.fault_addr) == m_addr) return bus.fault_val;
        return m_mem[m_addr];
    endfunction

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) begin
            bit miss;
            int a;
            a    = m_addr;
            miss = bus.read && (model_rd() != bus.data);
            if (miss) begin
                if (m_err < CMAX) m_err = m_err + 1;
                if (!m_fail_vld) begin
                    m_fail_vld  = 1'b1;
                    m_fail_addr = a;
                end
            end
            if (bus.write) m_mem[a] = bus.data;
            if (bus.reset)       m_addr = 0;
            else if (bus.preset) m_addr = DEPTH - 1;
            else if (bus.en)     m_addr = bus.up_down ? (a + 1) % DEPTH : (a + DEPTH - 1) % DEPTH;
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        int exp_carry;
        int exp_eq;
        exp_carry = bus.en && (bus.up_down ? (m_addr == DEPTH - 1) : (m_addr == 0));
        exp_eq    = !bus.read || (model_rd() == bus.data);
        chk("cyc_addr",      bus.addr,      m_addr);
        chk("cyc_carry",     bus.carry,     exp_carry);
        chk("cyc_is_equal",  bus.is_equal,  exp_eq);
        chk("cyc_fail_vld",  bus.fail_vld,  m_fail_vld);
        chk("cyc_fail_addr", bus.fail_addr, m_fail_addr);
        chk("cyc_err_cnt",   bus.err_cnt,   m_err);
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        bus.reset   = 1'b0;
        bus.preset  = 1'b0;
        bus.en      = 1'b0;
        bus.up_down = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.data    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_strobe();
        idle();
        bus.reset = 1'b1;
        cyc();
        bus.reset = 1'b0;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        idle();
        bus.fault_en   = 1'b0;
        bus.fault_addr = '0;
        bus.fault_val  = 1'b0;
        #2;
        chk("rst_addr",     bus.addr,     0);
        chk("rst_carry",    bus.carry,    0);
        chk("rst_is_equal", bus.is_equal, 1);
        chk("rst_fail_vld", bus.fail_vld, 0);
        chk("rst_err_cnt",  bus.err_cnt,  0);
        bus.read = 1'b1;
        bus.data = 1'b0;
        #1 chk("rst_read0_eq", bus.is_equal, 1);
        bus.data = 1'b1;
        #1 chk("rst_read1_ne", bus.is_equal, 0);
        idle();
        bus.en = 1'b1;
        #1 chk("rst_carry_down", bus.carry, 1);
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;

        // Up write sweep of ones.
        do_reset_strobe();
        bus.en = 1'b1; bus.up_down = 1'b1; bus.write = 1'b1; bus.data = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("up_addr",  bus.addr,  i);
            chk("up_carry", bus.carry, (i == DEPTH - 1));
            cyc();
        end
        idle();
        #1 chk("up_wrap", bus.addr, 0);

        // Down read sweep expecting ones.
        idle();
        bus.preset = 1'b1;
        cyc();
        idle();
        bus.en = 1'b1; bus.up_down = 1'b0; bus.read = 1'b1; bus.data = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("dn_addr",  bus.addr,     DEPTH - 1 - i);
            chk("dn_eq",    bus.is_equal, 1);
            chk("dn_carry", bus.carry,    (i == DEPTH - 1));
            cyc();
        end
        idle();
        #1 chk("dn_err_cnt", bus.err_cnt, 0);

        // Clear array, then sweep with a stuck-at-1 on cell 5.
        do_reset_strobe();
        bus.en = 1'b1; bus.up_down = 1'b1; bus.write = 1'b1; bus.data = 1'b0;
        repeat (DEPTH) cyc();
        do_reset_strobe();
        bus.fault_en = 1'b1; bus.fault_addr = 4'd5; bus.fault_val = 1'b1;
        bus.en = 1'b1; bus.up_down = 1'b1; bus.read = 1'b1; bus.data = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1 chk("flt_eq", bus.is_equal, (i != 5));
            cyc();
        end
        #1;
        chk("flt_fail_vld",  bus.fail_vld,  1);
        chk("flt_fail_addr", bus.fail_addr, 5);
        chk("flt_err_1",     bus.err_cnt,   1);
        repeat (DEPTH) cyc();
        #1;
        chk("flt_err_2",      bus.err_cnt,   2);
        chk("flt_fail_addr2", bus.fail_addr, 5);
        bus.fault_en = 1'b0;
        idle();

        // Counter priority.
        do_reset_strobe();
        bus.en = 1'b1; bus.up_down = 1'b1;
        repeat (9) cyc();
        #1 chk("pri_at9", bus.addr, 9);
        bus.reset = 1'b1; bus.preset = 1'b1;
        cyc();
        #1 chk("pri_reset_wins", bus.addr, 0);
        bus.reset = 1'b0; bus.preset = 1'b1; bus.up_down = 1'b0;
        cyc();
        #1 chk("pri_preset_wins", bus.addr, 15);
        idle();

        // Simultaneous read+write on cell 15 (holds 0).
        bus.read = 1'b1; bus.write = 1'b1; bus.data = 1'b1;
        #1 chk("rw_pre_write", bus.is_equal, 0);
        cyc();
        idle();
        bus.read = 1'b1; bus.data = 1'b1;
        #1 chk("rw_post_write", bus.is_equal, 1);
        cyc();
        #1;
        chk("rw_err_3",     bus.err_cnt,   3);
        chk("rw_fail_addr", bus.fail_addr, 5);

        // Saturate the mismatch counter on cell 15 (now 1).
        bus.read = 1'b1; bus.data = 1'b0;
        repeat (260) cyc();
        #1 chk("sat_err", bus.err_cnt, CMAX);
        idle();

        // Async reset in the middle of a ones write sweep.
        do_reset_strobe();
        bus.en = 1'b1; bus.up_down = 1'b1; bus.write = 1'b1; bus.data = 1'b1;
        repeat (7) cyc();
        #1 chk("ar_at7", bus.addr, 7);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_addr",     bus.addr,     0);
        chk("ar_err_cnt",  bus.err_cnt,  0);
        chk("ar_fail_vld", bus.fail_vld, 0);
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
        bus.en = 1'b1; bus.up_down = 1'b1; bus.read = 1'b1; bus.data = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1 chk("ar_read0_eq", bus.is_equal, 1);
            cyc();
        end
        idle();
        #1 chk("ar_final_err", bus.err_cnt, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
